oled_init_seq: RTL and testbench



---
 rtl/oled_init_seq.sv | 137 +++++++++++++
 tb/tb_oled_init_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/oled_init_seq.sv
// oled_init_seq: SSD1306-class OLED power-up reset, init-command stream and display clear sequencer
// Ports: clk/rst_n clock and async active-low reset; start re-init request (honoured in DONE/ERROR);
// fill_pattern clear byte (latched leaving RST_HOLD); write_done SPI byte-complete pulse;
// oled_rst panel reset (active low); oled_dc 0=cmd 1=data; data/ena_write byte and one-cycle request;
// init_done/busy/timeout_err status derived from the registered state.
module oled_init_seq #(
  parameter int RST_CYCLES = 10,
  parameter int PAGES      = 8,
  parameter int COLS       = 128,
  parameter int WD_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] fill_pattern,
  input  logic       write_done,
  output logic       oled_rst,
  output logic       oled_dc,
  output logic [7:0] data,
  output logic       ena_write,
  output logic       init_done,
  output logic       busy,
  output logic       timeout_err
);
  localparam int RW = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;
  localparam int PW = PAGES > 1 ? $clog2(PAGES) : 1;
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  localparam int WW = $clog2(WD_TIMEOUT);
  localparam logic [7:0] INIT_TBL [25] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14, 8'h20, 8'h02, 8'hA1,
    8'hC0, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
  typedef enum logic [3:0] {
    RST_HOLD, CMD, CMD_WAIT, PG_CMD, PG_WAIT, DATA, DATA_WAIT, DONE, ERROR
  } state_t;
  state_t         state_q;
  logic [RW-1:0]  rst_cnt_q;
  logic [4:0]     idx_q;
  logic [1:0]     sub_q;
  logic [PW-1:0]  page_q;
  logic [CW-1:0]  col_q;
  logic [WW-1:0]  wd_q;
  logic [7:0]     fill_q, data_q;
  logic           oled_rst_q, dc_q, ena_q;
  logic           last_col, last_page, wd_exp, waiting;
  assign last_col  = col_q == CW'(COLS - 1);
  assign last_page = page_q == PW'(PAGES - 1);
  assign wd_exp    = wd_q == WW'(WD_TIMEOUT - 1);
  assign waiting   = state_q inside {CMD_WAIT, PG_WAIT, DATA_WAIT};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= RST_HOLD;
      rst_cnt_q  <= '0;
      idx_q      <= '0;
      sub_q      <= '0;
      page_q     <= '0;
      col_q      <= '0;
      wd_q       <= '0;
      fill_q     <= '0;
      data_q     <= '0;
      oled_rst_q <= 1'b0;
      dc_q       <= 1'b0;
      ena_q      <= 1'b0;
    end else begin
      ena_q <= 1'b0;
      case (state_q)
        RST_HOLD:
          if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
            fill_q     <= fill_pattern;
            oled_rst_q <= 1'b1;
            rst_cnt_q  <= '0;
            state_q    <= CMD;
          end else rst_cnt_q <= rst_cnt_q + 1'b1;
        CMD: begin
          ena_q   <= 1'b1;
          dc_q    <= 1'b0;
          data_q  <= INIT_TBL[idx_q];
          wd_q    <= '0;
          state_q <= CMD_WAIT;
        end
        PG_CMD: begin
          ena_q   <= 1'b1;
          dc_q    <= 1'b0;
          data_q  <= sub_q == 2'd0 ? 8'hB0 + 8'(page_q) : sub_q == 2'd1 ? 8'h00 : 8'h10;
          wd_q    <= '0;
          state_q <= PG_WAIT;
        end
        DATA: begin
          ena_q   <= 1'b1;
          dc_q    <= 1'b1;
          data_q  <= fill_q;
          wd_q    <= '0;
          state_q <= DATA_WAIT;
        end
        CMD_WAIT:
          if (write_done) begin
            idx_q   <= idx_q + 1'b1;
            state_q <= idx_q == 5'd24 ? PG_CMD : CMD;
          end
        PG_WAIT:
          if (write_done) begin
            sub_q   <= sub_q == 2'd2 ? 2'd0 : sub_q + 1'b1;
            col_q   <= '0;
            state_q <= sub_q == 2'd2 ? DATA : PG_CMD;
          end
        DATA_WAIT:
          if (write_done) begin
            col_q   <= last_col ? '0 : col_q + 1'b1;
            page_q  <= last_col && !last_page ? page_q + 1'b1 : page_q;
            state_q <= !last_col ? DATA : last_page ? DONE : PG_CMD;
          end
        DONE, ERROR:
          if (start) begin
            state_q    <= RST_HOLD;
            oled_rst_q <= 1'b0;
            rst_cnt_q  <= '0;
            idx_q      <= '0;
            sub_q      <= '0;
            page_q     <= '0;
            col_q      <= '0;
            wd_q       <= '0;
          end
        default: state_q <= RST_HOLD;
      endcase
      // Shared watchdog for all wait states; a write_done on the expiring cycle takes priority.
      if (waiting && !write_done) begin
        if (wd_exp) state_q <= ERROR;
        else wd_q <= wd_q + 1'b1;
      end
    end
  assign oled_rst    = oled_rst_q;
  assign oled_dc     = dc_q;
  assign data        = data_q;
  assign ena_write   = ena_q;
  assign init_done   = state_q == DONE;
  assign busy        = !(state_q inside {DONE, ERROR});
  assign timeout_err = state_q == ERROR;
endmodule

// File: tb/tb_oled_init_seq.sv
// tb_oled_init_seq: directed self-checking bench for oled_init_seq (small config and default config)
module tb_oled_init_seq;
  localparam logic [7:0] TBL [25] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14, 8'h20, 8'h02, 8'hA1,
    8'hC0, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
  logic       clk, rst_n, rst_nb;
  logic       start_a, wd_a, start_b, wd_b;
  logic [7:0] fill_a, data_a, data_b;
  logic       orst_a, dc_a, ena_a, done_a, busy_a, terr_a;
  logic       orst_b, dc_b, ena_b, done_b, busy_b, terr_b;
  int         checks = 0, failures = 0;
  int         pulses_a = 0, pulses_b = 0;
  oled_init_seq #(.RST_CYCLES(5), .PAGES(2), .COLS(4), .WD_TIMEOUT(16)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .fill_pattern(fill_a), .write_done(wd_a),
    .oled_rst(orst_a), .oled_dc(dc_a), .data(data_a), .ena_write(ena_a),
    .init_done(done_a), .busy(busy_a), .timeout_err(terr_a));
  oled_init_seq u_b (
    .clk(clk), .rst_n(rst_nb), .start(start_b), .fill_pattern(8'h33), .write_done(wd_b),
    .oled_rst(orst_b), .oled_dc(dc_b), .data(data_b), .ena_write(ena_b),
    .init_done(done_b), .busy(busy_b), .timeout_err(terr_b));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(negedge clk) begin
    if (ena_a) pulses_a <= pulses_a + 1;
    if (ena_b) pulses_b <= pulses_b + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Write i of a 2-page x 4-col sequence: 25 init bytes, then per page B0+p, 00, 10, 4 fill bytes.
  function automatic logic [7:0] exp_data(input int i, input logic [7:0] f);
    int r;
    r = (i - 25) % 7;
    if (i < 25) return TBL[i];
    if (r == 0) return 8'hB0 + 8'((i - 25) / 7);
    if (r == 1) return 8'h00;
    if (r == 2) return 8'h10;
    return f;
  endfunction
  task automatic rst_low(input string tag);
    int n = 0;
    while (!orst_a && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk(tag, n, 5);
  endtask
  // Serves up to 39 writes; stops without answering write stop_at, answers write slow_at late.
  task automatic run_seq(input int stop_at, input int slow_at, input int chg_at, input logic [7:0] fexp);
    int k;
    for (int i = 0; i < 39; i++) begin
      k = 0;
      while (!ena_a && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk($sformatf("ena_seen%0d", i), ena_a, 1);
      if (!ena_a) return;
      chk($sformatf("dc%0d", i), dc_a, (i >= 25 && (i - 25) % 7 >= 3) ? 1 : 0);
      chk($sformatf("data%0d", i), data_a, exp_data(i, fexp));
      if (i == chg_at) fill_a = 8'hFF;
      if (i == stop_at) return;
      repeat (i == slow_at ? 15 : 3) @(negedge clk);
      wd_a = 1'b1;
      @(negedge clk);
      wd_a = 1'b0;
    end
  endtask
  task automatic restart_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask
  initial begin
    int p0, k;
    rst_n = 1'b0; rst_nb = 1'b0;
    start_a = 1'b0; wd_a = 1'b0; start_b = 1'b0; wd_b = 1'b0; fill_a = 8'h5A;
    repeat (2) @(negedge clk);
    chk("rst_oled_rst", orst_a, 0);
    chk("rst_dc", dc_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_ena", ena_a, 0);
    chk("rst_init_done", done_a, 0);
    chk("rst_busy", busy_a, 1);
    chk("rst_terr", terr_a, 0);
    rst_n = 1'b1;
    rst_low("rst_hold_len");
    p0 = pulses_a;
    run_seq(-1, -1, 28, 8'h5A);
    chk("seq1_init_done", done_a, 1);
    chk("seq1_busy", busy_a, 0);
    repeat (5) @(negedge clk);
    chk("seq1_pulses", pulses_a - p0, 39);
    chk("seq1_ena_idle", ena_a, 0);
    restart_a();
    chk("restart_busy", busy_a, 1);
    rst_low("restart_hold_len");
    p0 = pulses_a;
    run_seq(9, -1, -1, 8'hFF);
    k = 0;
    while (!terr_a && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("wd_cycles", k, 16);
    wd_a = 1'b1;
    @(negedge clk);
    wd_a = 1'b0;
    repeat (10) @(negedge clk);
    chk("err_terr", terr_a, 1);
    chk("err_busy", busy_a, 0);
    chk("err_init_done", done_a, 0);
    chk("err_ena", ena_a, 0);
    chk("err_pulses", pulses_a - p0, 10);
    restart_a();
    chk("err_clear", terr_a, 0);
    rst_low("err_hold_len");
    p0 = pulses_a;
    run_seq(-1, -1, -1, 8'hFF);
    chk("err_seq_done", done_a, 1);
    chk("err_seq_pulses", pulses_a - p0, 39);
    restart_a();
    rst_low("edge_hold_len");
    run_seq(-1, 9, -1, 8'hFF);
    chk("edge_terr", terr_a, 0);
    chk("edge_done", done_a, 1);
    restart_a();
    rst_low("mid_hold_len");
    run_seq(36, -1, -1, 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_oled_rst", orst_a, 0);
    chk("mid_dc", dc_a, 0);
    chk("mid_data", data_a, 0);
    chk("mid_ena", ena_a, 0);
    chk("mid_busy", busy_a, 1);
    chk("mid_init_done", done_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rst_low("mid_rel_hold_len");
    run_seq(-1, -1, -1, 8'hFF);
    chk("mid_seq_done", done_a, 1);
    rst_nb = 1'b1;
    for (int c = 0; c < 5000 && !done_b; c++) begin
      wd_b = ena_b;
      start_b = c == 300;
      @(negedge clk);
    end
    wd_b = 1'b0;
    start_b = 1'b0;
    chk("dflt_done", done_b, 1);
    chk("dflt_busy", busy_b, 0);
    chk("dflt_pulses", pulses_b, 1073);
    chk("dflt_last_byte", data_b, 8'h33);
    chk("dflt_last_dc", dc_b, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
